// File: rtl/wbm_byte_bridge_if.sv
// Bundles the byte-stream and Wishbone master signals of wbm_byte_bridge.
// Signal names carry the bridge's point of view (_i = into the bridge).
//
// Handshakes: a byte moves on a rising clock edge where valid and ready are
// both high. The sender holds data stable while valid is high and ready is
// low. The sender never waits for ready before raising valid. Wishbone is
// classic single-cycle: the master holds cyc/stb until it samples ack or err.
`timescale 1ns/1ps
interface wbm_byte_bridge_if #(
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 8
);
    logic [7:0]                  rx_data_i;
    logic                        rx_valid_i;
    logic                        rx_ready_o;
    logic [7:0]                  tx_data_o;
    logic                        tx_valid_o;
    logic                        tx_ready_i;
    logic                        wbm_cyc_o;
    logic                        wbm_stb_o;
    logic                        wbm_we_o;
    logic [BUS_DATA_WIDTH/8-1:0] wbm_sel_o;
    logic [BUS_ADDR_WIDTH-1:0]   wbm_adr_o;
    logic [BUS_DATA_WIDTH-1:0]   wbm_dat_o;
    logic [BUS_DATA_WIDTH-1:0]   wbm_dat_i;
    logic                        wbm_ack_i;
    logic                        wbm_err_i;

    modport master (
        input  rx_data_i, rx_valid_i, tx_ready_i, wbm_dat_i, wbm_ack_i, wbm_err_i,
        output rx_ready_o, tx_data_o, tx_valid_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output rx_data_i, rx_valid_i, tx_ready_i, wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  rx_ready_o, tx_data_o, tx_valid_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );
endinterface

// File: rtl/wbm_byte_bridge.sv
// Byte-stream to Wishbone master bridge.
// Commands: 'W' (0x57) + addr + data, or 'R' (0x52) + addr, fields sent MSB first.
// It replies 0x06 (ok) or 0x15 (fail). An ok read is followed by its data bytes.
// Only one transaction is in flight at a time.
// Optional macro WBM_TIMEOUT_EN: abort a bus cycle after TIMEOUT_CYCLES without ack/err.
`timescale 1ns/1ps
module wbm_byte_bridge #(
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    wbm_byte_bridge_if.master    bus,
    output logic                 busy_o,
    output logic [2:0]           dbg_state_o
);
    localparam int DAT_BYTES = BUS_DATA_WIDTH / 8;
    localparam int ADR_BYTES = (BUS_ADDR_WIDTH + 7) / 8;
    localparam int ADR_SH_W  = ADR_BYTES * 8;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] ST_OK   = 8'h06;
    localparam logic [7:0] ST_FAIL = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GET_ADR = 3'd1,
        S_GET_DAT = 3'd2,
        S_BUS_REQ = 3'd3,
        S_BUS_END = 3'd4,
        S_TX_STAT = 3'd5,
        S_TX_DAT  = 3'd6
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic                        r_we;
    logic [ADR_SH_W-1:0]         r_adr;
    logic [BUS_DATA_WIDTH-1:0]   r_dat;
    logic [3:0]                  r_cnt;
    logic [7:0]                  r_stat;

    logic w_rx_fire;
    logic w_tx_fire;
    logic w_adr_last;
    logic w_dat_last;
    logic w_tmo_hit;
    logic w_bus_done;

    assign w_rx_fire  = bus.rx_valid_i & bus.rx_ready_o;
    assign w_tx_fire  = bus.tx_valid_o & bus.tx_ready_i;
    assign w_adr_last = (r_cnt == 4'(ADR_BYTES - 1));
    assign w_dat_last = (r_cnt == 4'(DAT_BYTES - 1));
    assign w_bus_done = bus.wbm_ack_i | bus.wbm_err_i | w_tmo_hit;

`ifdef WBM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo;

    // Count cycles spent in BUS_REQ; cleared elsewhere so every entry starts at zero.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i)               r_tmo <= '0;
        else if (r_state == S_BUS_REQ) r_tmo <= r_tmo + 1'b1;
        else                           r_tmo <= '0;
    end

    assign w_tmo_hit = (r_state == S_BUS_REQ) && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    // Never fires: without the timeout the bus wait is unbounded.
    assign w_tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    // Next-state and handshake/strobe outputs.
    always_comb begin
        w_next         = r_state;
        bus.rx_ready_o = 1'b0;
        bus.tx_valid_o = 1'b0;
        bus.wbm_cyc_o  = 1'b0;
        bus.wbm_stb_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.rx_ready_o = 1'b1;
                if (w_rx_fire) begin
                    if (bus.rx_data_i == OP_WR || bus.rx_data_i == OP_RD) w_next = S_GET_ADR;
                    else                                                    w_next = S_TX_STAT;
                end
            end
            S_GET_ADR: begin
                // The final command byte is held off while a stale ack is still high,
                // so BUS_REQ is only ever entered with ack low.
                bus.rx_ready_o = !(w_adr_last && !r_we && bus.wbm_ack_i);
                if (w_rx_fire && w_adr_last) w_next = r_we ? S_GET_DAT : S_BUS_REQ;
            end
            S_GET_DAT: begin
                bus.rx_ready_o = !(w_dat_last && bus.wbm_ack_i);
                if (w_rx_fire && w_dat_last) w_next = S_BUS_REQ;
            end
            S_BUS_REQ: begin
                bus.wbm_cyc_o = 1'b1;
                bus.wbm_stb_o = 1'b1;
                if (w_bus_done) w_next = S_BUS_END;
            end
            S_BUS_END: begin
                if (!bus.wbm_ack_i) w_next = S_TX_STAT;
            end
            S_TX_STAT: begin
                bus.tx_valid_o = 1'b1;
                if (w_tx_fire) w_next = (!r_we && r_stat == ST_OK) ? S_TX_DAT : S_IDLE;
            end
            S_TX_DAT: begin
                bus.tx_valid_o = 1'b1;
                if (w_tx_fire && w_dat_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register plus command/address/data/status capture.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_cnt   <= '0;
            r_stat  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_rx_fire) begin
                        r_cnt <= '0;
                        if (bus.rx_data_i == OP_WR)      r_we   <= 1'b1;
                        else if (bus.rx_data_i == OP_RD) r_we   <= 1'b0;
                        else                             r_stat <= ST_FAIL;
                    end
                end
                S_GET_ADR: begin
                    if (w_rx_fire) begin
                        r_adr <= (r_adr << 8) | ADR_SH_W'(bus.rx_data_i);
                        r_cnt <= w_adr_last ? 4'd0 : r_cnt + 4'd1;
                    end
                end
                S_GET_DAT: begin
                    if (w_rx_fire) begin
                        r_dat <= (r_dat << 8) | BUS_DATA_WIDTH'(bus.rx_data_i);
                        r_cnt <= w_dat_last ? 4'd0 : r_cnt + 4'd1;
                    end
                end
                S_BUS_REQ: begin
                    if (bus.wbm_err_i) begin
                        r_stat <= ST_FAIL;
                    end else if (bus.wbm_ack_i) begin
                        r_stat <= ST_OK;
                        if (!r_we) r_dat <= bus.wbm_dat_i;
                    end else if (w_tmo_hit) begin
                        r_stat <= ST_FAIL;
                    end
                end
                S_TX_DAT: begin
                    // Read data leaves MSB first by shifting the next byte to the top.
                    if (w_tx_fire) begin
                        r_dat <= r_dat << 8;
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.tx_data_o = (r_state == S_TX_DAT) ? r_dat[BUS_DATA_WIDTH-1 -: 8] : r_stat;
    assign bus.wbm_we_o  = r_we;
    assign bus.wbm_sel_o = '1;
    assign bus.wbm_adr_o = r_adr[BUS_ADDR_WIDTH-1:0];
    assign bus.wbm_dat_o = r_dat;
    assign busy_o        = (r_state != S_IDLE);
    assign dbg_state_o   = r_state;
endmodule
